axi_burst_mem_slave: RTL
========================

// Module: axi_burst_mem_slave
// PURPOSE
//  AXI-full responder backing the cache miss/writeback port with a 64-bit word SRAM model.
//  Serves INCR/FIXED read bursts for line refills and write bursts for dirty-line writebacks.
//  Read and write channels run independent FSMs. Sits below the dcache/icache bus ports in the simulated SoC.
// PARAMETERS
//  MEM_WORDS     1024          number of 64-bit words (8 KiB); power of two
//  BASE_ADDR     32'h80000000  byte address of word 0
//  LEN_IS_BEATS  1             1: beats = (len==0 ? 1 : len); 0: beats = len+1 (AXI standard)
//  B_WAIT        1             1: bvalid held until bready; 0: bvalid is a 1-cycle pulse
// PORTS
//  clk      in   1   clock
//  rst      in   1   synchronous active-high reset
//  araddr   in   32  read burst start byte address
//  arvalid  in   1   read address valid
//  arburst  in   2   00 FIXED, 01 INCR, 10 treated as INCR
//  arlen    in   8   burst length, interpreted per LEN_IS_BEATS
//  arsize   in   3   must be 3 (8 B/beat); other values treated as 3
//  arready  out  1   read address ready
//  rdata    out  64  read data
//  rresp    out  2   always 2'b00
//  rvalid   out  1   read data valid
//  rlast    out  1   final read beat
//  rready   in   1   master accepts read beat
//  awaddr   in   32  write burst start byte address
//  awvalid  in   1   write address valid
//  awburst  in   2   as arburst
//  awlen    in   8   as arlen
//  awready  out  1   write address ready
//  wdata    in   64  write data
//  wlast    in   1   master's last-beat marker
//  wstrb    in   8   byte enables; bit i writes wdata[8i+7:8i]
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  bresp    out  2   00 OKAY, 10 SLVERR (beat-count mismatch)
//  bvalid   out  1   write response valid
//  bready   in   1   master accepts response
// BEHAVIOUR
//  Word index = ((addr - BASE_ADDR) >> 3) mod MEM_WORDS; addr[2:0] ignored; out-of-range wraps, no error.
//  Beat address: INCR +8 per beat (index wraps at MEM_WORDS); FIXED constant.
//  Reset: arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rresp=0, bresp=0, rdata=0,
//   counters 0, both FSMs idle; reset mid-burst aborts it. Memory contents are not cleared.
//  Read FSM:
//   R_IDLE: arready=1. On arvalid&arready, latch address, burst type, and beat count.
//    Go to R_DATA with rdata = mem[start] registered (first rvalid one cycle after the handshake).
//   R_DATA: arready=0, rvalid=1. rdata/rvalid/rlast held stable until rready.
//    On rvalid&rready: if last beat, go to R_IDLE; else load next word the same edge (no bubble).
//   rlast=1 exactly on beat N (N = decoded beat count).
//  Write FSM:
//   W_IDLE: awready=1. On awvalid&awready, latch address, type, and count; go to W_DATA.
//   W_DATA: wready=1. On each wvalid&wready, write enabled bytes at the current word.
//    Burst ends on the earlier of (wlast) or (Nth beat accepted); then go to W_RESP.
//    bresp=10 if wlast and the Nth beat did not coincide, else 00.
//   W_RESP: bvalid=1, wready=0, awready=0. B_WAIT=1: leave on bready. B_WAIT=0: leave after one cycle.
//  Same-cycle read-word load and write to one word: read returns pre-write data.
//  AR and AW accepted in the same cycle are both taken.
//  Beat counter: 9 bits; len=0 with LEN_IS_BEATS=1 is a single beat.
// TESTING
//  1. Preload mem[0..7]=i, araddr=80000000, arlen=8, rready=1 -> rvalid one cycle after AR;
//     8 back-to-back beats 0..7; rlast only on beat 8; arready=1 the cycle after.
//  2. Same read with rready toggled 1/0 -> rdata/rlast stable while stalled; order 0..7 intact.
//  3. AW 80000040 len 8, data i+100, wstrb FF, wlast on beat 8 -> bresp=00;
//     read-back returns 100..107; bvalid holds until bready (B_WAIT=1).
//  4. Write wstrb=0F, data 1122334455667788 over FFFF...FF -> word reads FFFFFFFF55667788.
//  5. wlast on beat 3 of len 8 -> bresp=10 after beat 3; beats 4..8 not written.
//     Second case: no wlast by beat 8 -> burst ends after beat 8, bresp=10.
//  6. Reset asserted mid read burst at beat 4 -> next cycle rvalid=0, arready=1; new burst restarts cleanly.

Source files
------------

// File: rtl/axi_burst_mem_slave_if.sv
// AXI-full bus bundle between a cache-side master and axi_burst_mem_slave.
// Latency: none, wiring only.
// Backpressure: carried by the valid/ready pair of each channel.
interface axi_burst_mem_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;
    logic [63:0] wdata;
    logic        wlast;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize, rready,
        output awaddr, awvalid, awburst, awlen, wdata, wlast, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, rlast,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize, rready,
        input  awaddr, awvalid, awburst, awlen, wdata, wlast, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, rlast,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI-full burst responder over a 64-bit word SRAM model, independent read and write FSMs.
// Latency: first rvalid one cycle after AR handshake, then one beat per cycle; bvalid the cycle after the final W beat.
// Backpressure: rdata/rlast hold until rready; bvalid holds until bready (B_WAIT=1); wready only in the data phase.
module axi_burst_mem_slave #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter bit          LEN_IS_BEATS = 1'b1,
    parameter bit          B_WAIT       = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    axi_burst_mem_slave_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic [8:0] beats_of(input logic [7:0] len);
        if (LEN_IS_BEATS) begin
            return (len == 8'd0) ? 9'd1 : {1'b0, len};
        end
        return {1'b0, len} + 9'd1;
    endfunction

    logic [63:0] mem [MEM_WORDS];

    // Word index is the byte offset from BASE_ADDR, dropping the byte lane bits; the
    // truncation to IDX_W bits gives the wrap at MEM_WORDS for free.
    logic [31:0] ar_off, aw_off;
    idx_t        ar_idx, aw_idx;
    logic [8:0]  ar_beats, aw_beats;
    logic        unused_bits;

    assign ar_off      = bus.araddr - BASE_ADDR;
    assign aw_off      = bus.awaddr - BASE_ADDR;
    assign ar_idx      = ar_off[IDX_W+2:3];
    assign aw_idx      = aw_off[IDX_W+2:3];
    assign ar_beats    = beats_of(bus.arlen);
    assign aw_beats    = beats_of(bus.awlen);
    assign unused_bits = ^{ar_off[31:IDX_W+3], ar_off[2:0], aw_off[31:IDX_W+3], aw_off[2:0], bus.arsize};

    // Read channel state
    r_state_e    r_state_q, r_state_d;
    idx_t        r_idx_q, r_idx_d, r_next_idx;
    logic        r_fixed_q, r_fixed_d;
    logic [8:0]  r_left_q, r_left_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rlast_q, rlast_d;

    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_fixed_d  = r_fixed_q;
        r_left_d   = r_left_q;
        rdata_d    = rdata_q;
        rlast_d    = rlast_q;
        r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + idx_t'(1);
        unique case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_state_d = R_DATA;
                    r_idx_d   = ar_idx;
                    r_fixed_d = (bus.arburst == 2'b00);
                    r_left_d  = ar_beats;
                    rdata_d   = mem[ar_idx];
                    rlast_d   = (ar_beats == 9'd1);
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        // Next word is fetched on the accepting edge so beats stream without a bubble.
                        r_idx_d  = r_next_idx;
                        r_left_d = r_left_q - 9'd1;
                        rdata_d  = mem[r_next_idx];
                        rlast_d  = (r_left_q == 9'd2);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = 2'b00;

    // Write channel state
    w_state_e    w_state_q, w_state_d;
    idx_t        w_idx_q, w_idx_d;
    logic        w_fixed_q, w_fixed_d;
    logic [8:0]  w_beats_q, w_beats_d;
    logic [8:0]  w_cnt_q, w_cnt_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [8:0]  w_beat_no;
    logic        w_nth;
    logic        mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_fixed_d = w_fixed_q;
        w_beats_d = w_beats_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        w_beat_no = w_cnt_q + 9'd1;
        w_nth     = (w_beat_no == w_beats_q);
        unique case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_state_d = W_DATA;
                    w_idx_d   = aw_idx;
                    w_fixed_d = (bus.awburst == 2'b00);
                    w_beats_d = aw_beats;
                    w_cnt_d   = 9'd0;
                    bresp_d   = 2'b00;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we  = 1'b1;
                    w_cnt_d = w_beat_no;
                    w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + idx_t'(1);
                    // The burst closes on whichever comes first; disagreement is a SLVERR.
                    if (bus.wlast || w_nth) begin
                        w_state_d = W_RESP;
                        bresp_d   = (bus.wlast != w_nth) ? 2'b10 : 2'b00;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready || !B_WAIT) begin
                    w_state_d = W_IDLE;
                    bresp_d   = 2'b00;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = bresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_fixed_q <= 1'b0;
            r_left_q  <= 9'd0;
            rdata_q   <= 64'd0;
            rlast_q   <= 1'b0;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_fixed_q <= 1'b0;
            w_beats_q <= 9'd0;
            w_cnt_q   <= 9'd0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_fixed_q <= r_fixed_d;
            r_left_q  <= r_left_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_fixed_q <= w_fixed_d;
            w_beats_q <= w_beats_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
        end
    end

    // Storage survives reset; a read load on the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.wstrb[b]) begin
                    mem[w_idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
